// File: rtl/reg_status_file.sv
// Register file + NZC status register on the consumer side of the result bus.
// Writes are gated by a condition code evaluated on the registered flags.
// Reads are combinational onto tri-state operand buses.
module reg_status_file #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic             ld_reg,
  input  logic [3:0]       sel_in,
  input  logic             oe_a,
  input  logic [3:0]       sel_a,
  output tri   [WIDTH-1:0] data_bus,
  input  logic             oe_b,
  input  logic [3:0]       sel_b,
  output tri   [WIDTH-1:0] addr_bus,
  input  logic             ld_status,
  input  logic [2:0]       status_in,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic [2:0]       flags,
  output logic             carry_out
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [2:0]                     flags_q, flags_d;
  logic                           cond_ok;
  logic [WIDTH-1:0]               rd_a, rd_b;

  // Condition decode against the pre-edge flags (N=bit2, Z=bit1, C=bit0).
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'd0:    cond_ok = 1'b1;
      4'd1:    cond_ok = 1'b0;
      4'd2:    cond_ok = flags_q[1];
      4'd3:    cond_ok = !flags_q[1];
      4'd4:    cond_ok = flags_q[2];
      4'd5:    cond_ok = !flags_q[2];
      4'd6:    cond_ok = flags_q[0];
      4'd7:    cond_ok = !flags_q[0];
      4'd8:    cond_ok = flags_q[0] && !flags_q[1];
      4'd9:    cond_ok = !flags_q[0] || flags_q[1];
      4'd10:   cond_ok = !flags_q[2] && !flags_q[1];
      4'd11:   cond_ok = flags_q[2] || flags_q[1];
      default: cond_ok = 1'b0;
    endcase
  end

  // Next-state for registers and flags; indices with no register never match.
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (ld_reg && cond_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel_in == 4'(i)) regs_d[i] = result;
      end
    end
    if (ld_status && cond_ok) flags_d = status_in;
  end

  // State registers, async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  // Read muxes straight off the array; out-of-range selects yield 0.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_a == 4'(i)) rd_a = regs_q[i];
      if (sel_b == 4'(i)) rd_b = regs_q[i];
    end
  end

  assign data_bus  = oe_a ? rd_a : 'z;
  assign addr_bus  = oe_b ? rd_b : 'z;
  assign cond_true = cond_ok;
  assign flags     = flags_q;
  assign carry_out = flags_q[0];

  // An unknown result being committed is a bus protocol error upstream.
  a_result_known : assert property (@(posedge clk) disable iff (!rst_n)
    (ld_reg && cond_ok) |-> !$isunknown(result));

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file. Operand buses are pulled up here so a
// released bus reads all ones.
module tb_reg_status_file;
  localparam int W = 32;
  localparam int NR = 8;

  logic          clk, rst_n;
  logic [W-1:0]  result;
  logic          ld_reg, oe_a, oe_b, ld_status;
  logic [3:0]    sel_in, sel_a, sel_b, cond;
  logic [2:0]    status_in;
  tri1  [W-1:0]  data_bus, addr_bus;
  logic          cond_true, carry_out;
  logic [2:0]    flags;

  int total = 0;
  int bad   = 0;

  reg_status_file #(.NUM_REGS(NR), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .ld_reg(ld_reg), .sel_in(sel_in),
    .oe_a(oe_a), .sel_a(sel_a), .data_bus(data_bus), .oe_b(oe_b), .sel_b(sel_b),
    .addr_bus(addr_bus), .ld_status(ld_status), .status_in(status_in),
    .cond(cond), .cond_true(cond_true), .flags(flags), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and drop the load strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    ld_reg = 1'b0;
    ld_status = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; oe_a = 1'b1; oe_b = 1'b1; sel_a = 4'd3; sel_b = 4'd7;
    #2;
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL rst_data got %h want %h", data_bus, 32'h0); end
    total++; if (addr_bus !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want %h", addr_bus, 32'h0); end
    total++; if (flags !== 3'b000) begin bad++; $display("FAIL rst_flags got %b want 000", flags); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL rst_carry got %b want 0", carry_out); end
    oe_a = 1'b0; oe_b = 1'b0;
    #1;
    total++; if (data_bus !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_data_released got %h want ffffffff", data_bus); end
    total++; if (addr_bus !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_addr_released got %h want ffffffff", addr_bus); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    ld_reg = 1'b1; cond = 4'd0; sel_in = 4'd5; result = 32'hDEAD_BEEF;
    oe_a = 1'b1; sel_a = 4'd5;
    #1;
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL no_bypass got %h want %h", data_bus, 32'h0); end
    tick();
    total++; if (data_bus !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_r5 got %h want deadbeef", data_bus); end
    oe_b = 1'b1; sel_b = 4'd5;
    #1;
    total++; if (addr_bus !== 32'hDEAD_BEEF) begin bad++; $display("FAIL same_sel_b got %h want deadbeef", addr_bus); end
    total++; if (data_bus !== 32'hDEAD_BEEF) begin bad++; $display("FAIL same_sel_a got %h want deadbeef", data_bus); end
    oe_b = 1'b0;
  endtask

  // Sweep all 16 condition codes; bit c of exp is the expected cond_true.
  task automatic test_cond_table(input logic [15:0] exp, input logic [2:0] fl);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      total++;
      if (cond_true !== exp[c]) begin
        bad++; $display("FAIL cond_%0d flags=%b got %b want %b", c, fl, cond_true, exp[c]);
      end
    end
  endtask

  task automatic test_status();
    ld_status = 1'b1; status_in = 3'b011; cond = 4'd0;
    tick();
    total++; if (flags !== 3'b011) begin bad++; $display("FAIL status_load got %b want 011", flags); end
    total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL carry got %b want 1", carry_out); end
    test_cond_table(16'h0A65, 3'b011);
  endtask

  task automatic test_cond_write();
    oe_a = 1'b1; sel_a = 4'd2;
    ld_reg = 1'b1; cond = 4'd3; sel_in = 4'd2; result = 32'h55;
    tick();
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL ne_blocked got %h want %h", data_bus, 32'h0); end
    ld_reg = 1'b1; cond = 4'd6; sel_in = 4'd2; result = 32'h55;
    tick();
    total++; if (data_bus !== 32'h55) begin bad++; $display("FAIL cs_write got %h want %h", data_bus, 32'h55); end
  endtask

  task automatic test_simultaneous();
    ld_status = 1'b1; status_in = 3'b101; cond = 4'd0;
    tick();
    test_cond_table(16'h0959, 3'b101);
    ld_status = 1'b1; status_in = 3'b000; cond = 4'd0;
    tick();
    test_cond_table(16'h06A9, 3'b000);
    ld_reg = 1'b1; ld_status = 1'b1; cond = 4'd7; status_in = 3'b001;
    sel_in = 4'd1; result = 32'hAA; sel_a = 4'd1;
    tick();
    total++; if (data_bus !== 32'hAA) begin bad++; $display("FAIL simul_reg got %h want %h", data_bus, 32'hAA); end
    total++; if (flags !== 3'b001) begin bad++; $display("FAIL simul_flags got %b want 001", flags); end
    cond = 4'd7;
    #1;
    total++; if (cond_true !== 1'b0) begin bad++; $display("FAIL simul_cc_after got %b want 0", cond_true); end
  endtask

  task automatic test_out_of_range();
    ld_reg = 1'b1; cond = 4'd0; sel_in = 4'd9; result = 32'h99;
    tick();
    oe_a = 1'b1; sel_a = 4'd9; oe_b = 1'b1; sel_b = 4'd1;
    #1;
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL oor_read got %h want %h", data_bus, 32'h0); end
    total++; if (addr_bus !== 32'hAA) begin bad++; $display("FAIL oor_no_alias got %h want %h", addr_bus, 32'hAA); end
    sel_a = 4'd1;
    #1;
    total++; if (data_bus !== addr_bus || data_bus !== 32'hAA) begin bad++; $display("FAIL dual_same got %h/%h want aa", data_bus, addr_bus); end
    oe_b = 1'b0;
  endtask

  task automatic test_async_reset();
    ld_reg = 1'b1; cond = 4'd0; sel_in = 4'd4; result = 32'h1234;
    tick();
    sel_a = 4'd4;
    #1;
    total++; if (data_bus !== 32'h1234) begin bad++; $display("FAIL r4_before got %h want %h", data_bus, 32'h1234); end
    rst_n = 1'b0;
    #1;
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL r4_async got %h want %h", data_bus, 32'h0); end
    total++; if (flags !== 3'b000) begin bad++; $display("FAIL flags_async got %b want 000", flags); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL carry_async got %b want 0", carry_out); end
    rst_n = 1'b1;
    // First edge after reset: EQ is false with Z=0, so reg6 stays clear.
    ld_reg = 1'b1; cond = 4'd2; sel_in = 4'd6; result = 32'h77; sel_a = 4'd6;
    tick();
    total++; if (data_bus !== 32'h0) begin bad++; $display("FAIL post_rst_eq got %h want %h", data_bus, 32'h0); end
    ld_reg = 1'b1; cond = 4'd9; sel_in = 4'd6; result = 32'h66;
    tick();
    total++; if (data_bus !== 32'h66) begin bad++; $display("FAIL post_rst_ls got %h want %h", data_bus, 32'h66); end
  endtask

  initial begin
    rst_n = 1'b0; result = '0; ld_reg = 1'b0; ld_status = 1'b0;
    sel_in = '0; sel_a = '0; sel_b = '0; oe_a = 1'b0; oe_b = 1'b0;
    status_in = '0; cond = '0;
    test_reset();
    test_write_read();
    test_status();
    test_cond_write();
    test_simultaneous();
    test_out_of_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Register file and status register on the consumer side of the result bus.
- Captures values driven onto the 32-bit result bus and NZC flags from the arithmetic unit.
- Drives stored registers back onto the data bus (operand a) and address bus (operand b) through tri-state outputs.
- Holds the carry fed back to the arithmetic unit and evaluates condition codes that gate all writes.

Parameters:
- NUM_REGS, 16, number of 32-bit general registers; power of two, 2..16.
- WIDTH, 32, register and bus width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- result  in  WIDTH  result bus; sampled when ld_reg is effective.
- ld_reg  in  1  write result into register sel_in.
- sel_in  in  4  destination register index.
- oe_a  in  1  drive register sel_a onto data_bus.
- sel_a  in  4  data-bus source index.
- data_bus  out (tri)  WIDTH  operand a bus.
- oe_b  in  1  drive register sel_b onto addr_bus.
- sel_b  in  4  address-bus source index.
- addr_bus  out (tri)  WIDTH  operand b bus.
- ld_status  in  1  load status_in into the flag register.
- status_in  in  3  NZC from the arithmetic unit; bit2 N, bit1 Z, bit0 C.
- cond  in  4  condition code gating both writes this cycle.
- cond_true  out  1  combinational condition result from current flags.
- flags  out  3  registered NZC.
- carry_out  out  1  equals flags[0]; feeds the arithmetic unit carry input.

Behaviour:
- Reset: asynchronous on rst_n low. All registers go to 0 and flags go to 3'b000 immediately, so carry_out=0. Buses follow the oe rules even during reset; they read 0 when enabled.
- Condition decode on the current registered flags:
  - 0 AL=1, 1 NV=0
  - 2 EQ=Z, 3 NE=!Z
  - 4 MI=N, 5 PL=!N
  - 6 CS=C, 7 CC=!C
  - 8 HI=C&!Z, 9 LS=!C|Z
  - 10 GT=!N&!Z, 11 LE=N|Z
  - 12-15 reserved, evaluate 0
- Register write: on a rising edge with ld_reg & cond_true, reg[sel_in] <= result.
- Status write: on a rising edge with ld_status & cond_true, flags <= status_in.
- Simultaneous ld_reg and ld_status: both evaluate cond against the pre-edge flags. The new flags affect cond_true only from the next cycle.
- Indices >= NUM_REGS: writes are ignored, and reads drive 0 when enabled.
- Reads:
  - data_bus = oe_a ? reg[sel_a] : 'z; addr_bus = oe_b ? reg[sel_b] : 'z.
  - Purely combinational from the register array; zero latency.
  - No write-to-read bypass. Reading the register being written returns the old value until after the edge.
- sel_a == sel_b with both oe high: both buses carry the same value.
- result containing x/z while ld_reg is effective is a protocol error. Assert in simulation; do not special-case in RTL.
- Reset deasserting mid-operation: the first rising edge after rst_n rises performs normal writes, with cond evaluated against flags=000.

Test Plan:
- Reset check: rst_n=0 with oe_a=oe_b=1, sel_a=3, sel_b=7 -> data_bus=0, addr_bus=0, flags=000, carry_out=0. Then oe_a=oe_b=0 -> both buses z.
- Basic write/read: ld_reg=1, cond=0, sel_in=5, result=32'hDEADBEEF, one edge; then oe_a=1, sel_a=5 -> data_bus=32'hDEADBEEF. Read of reg 5 in the same cycle as the write returns the old 0.
- Status load and carry: ld_status=1, status_in=3'b011, cond=0 -> flags=011, carry_out=1. Then cond=2 (EQ) gives cond_true=1; cond=10 (GT) gives 0; cond=13 gives 0.
- Conditional write: flags=011, ld_reg=1, cond=3 (NE), sel_in=2, result=32'h55 -> reg2 unchanged. With cond=6 (CS) -> reg2=32'h55.
- Simultaneous: flags=000, ld_reg=1 and ld_status=1, cond=7 (CC), status_in=3'b001, result=32'hAA to reg1 -> reg1=32'hAA, flags=001. Next cycle cond=7 gives cond_true=0.
- Async reset mid-operation: rst_n pulsed low between edges after reg4=32'h1234 -> reg4 reads 0 immediately, before the next clock edge.
